// File: rtl/axil_order_sequencer.sv
// AXI-Lite master that replays queued {addr,data} register-write orders in order,
// optionally polling a status register until nonzero before writing GATE_ADDR.
module axil_order_sequencer #(
  parameter int unsigned                AXIL_DATA_WIDTH = 32,
  parameter int unsigned                AXIL_ADDR_WIDTH = 8,
  parameter int unsigned                FIFO_DEPTH      = 16,
  parameter logic [AXIL_ADDR_WIDTH-1:0] GATE_ADDR       = 8'h48,
  parameter logic [AXIL_ADDR_WIDTH-1:0] STATUS_ADDR     = 8'h4c,
  parameter int unsigned                POLL_GAP        = 4,
  parameter int unsigned                CNT_WIDTH       = 16
) (
  input  logic                         m00_axi_aclk,
  input  logic                         m00_axi_aresetn,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [AXIL_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [AXIL_DATA_WIDTH-1:0]   cmd_data,
  input  logic                         gate_en,
  input  logic                         err_clr,
  output logic [AXIL_ADDR_WIDTH-1:0]   m00_axi_awaddr,
  output logic [2:0]                   m00_axi_awprot,
  output logic                         m00_axi_awvalid,
  input  logic                         m00_axi_awready,
  output logic [AXIL_DATA_WIDTH-1:0]   m00_axi_wdata,
  output logic [AXIL_DATA_WIDTH/8-1:0] m00_axi_wstrb,
  output logic                         m00_axi_wvalid,
  input  logic                         m00_axi_wready,
  input  logic [1:0]                   m00_axi_bresp,
  input  logic                         m00_axi_bvalid,
  output logic                         m00_axi_bready,
  output logic [AXIL_ADDR_WIDTH-1:0]   m00_axi_araddr,
  output logic [2:0]                   m00_axi_arprot,
  output logic                         m00_axi_arvalid,
  input  logic                         m00_axi_arready,
  input  logic [AXIL_DATA_WIDTH-1:0]   m00_axi_rdata,
  input  logic [1:0]                   m00_axi_rresp,
  input  logic                         m00_axi_rvalid,
  output logic                         m00_axi_rready,
  output logic                         busy,
  output logic [CNT_WIDTH-1:0]         sent_cnt,
  output logic                         resp_err
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned GW = $clog2(POLL_GAP + 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WR       = 3'd1;
  localparam logic [2:0] S_WR_B     = 3'd2;
  localparam logic [2:0] S_POLL_AR  = 3'd3;
  localparam logic [2:0] S_POLL_R   = 3'd4;
  localparam logic [2:0] S_POLL_GAP = 3'd5;

  logic [2:0]                 state;
  logic [AXIL_ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
  logic [AXIL_DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [PW-1:0]              wr_ptr, rd_ptr;
  logic [CW-1:0]              level, level_next;
  logic                       empty, push, pop;
  logic                       aw_done, w_done;
  logic                       aw_hs, w_hs, b_hs, r_hs;
  logic [GW-1:0]              gap_cnt;

  assign m00_axi_awprot = '0;
  assign m00_axi_arprot = '0;
  assign m00_axi_wstrb  = '1;

  assign empty = (level == '0);
  assign push  = cmd_valid && cmd_ready;
  assign pop   = (state == S_IDLE) && !empty;
  assign busy  = (state != S_IDLE) || !empty;

  assign aw_hs = m00_axi_awvalid && m00_axi_awready;
  assign w_hs  = m00_axi_wvalid  && m00_axi_wready;
  assign b_hs  = m00_axi_bvalid  && m00_axi_bready;
  assign r_hs  = m00_axi_rvalid  && m00_axi_rready;

  always_comb begin
    level_next = level;
    if (push && !pop)
      level_next = level + CW'(1);
    else if (!push && pop)
      level_next = level - CW'(1);
  end

  always_ff @(posedge m00_axi_aclk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= cmd_addr;
      fifo_data[wr_ptr] <= cmd_data;
    end
  end

  // cmd_ready is registered from the next level, so a pop while full only reopens it a cycle later
  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      cmd_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      level     <= level_next;
      cmd_ready <= (level_next != CW'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn) begin
      state           <= S_IDLE;
      m00_axi_awaddr  <= '0;
      m00_axi_awvalid <= 1'b0;
      m00_axi_wdata   <= '0;
      m00_axi_wvalid  <= 1'b0;
      m00_axi_bready  <= 1'b0;
      m00_axi_araddr  <= '0;
      m00_axi_arvalid <= 1'b0;
      m00_axi_rready  <= 1'b0;
      aw_done         <= 1'b0;
      w_done          <= 1'b0;
      gap_cnt         <= '0;
      sent_cnt        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!empty) begin
            // awaddr/wdata double as the current order registers
            m00_axi_awaddr <= fifo_addr[rd_ptr];
            m00_axi_wdata  <= fifo_data[rd_ptr];
            if (gate_en && fifo_addr[rd_ptr] == GATE_ADDR) begin
              state           <= S_POLL_AR;
              m00_axi_arvalid <= 1'b1;
              m00_axi_araddr  <= STATUS_ADDR;
            end else begin
              state           <= S_WR;
              m00_axi_awvalid <= 1'b1;
              m00_axi_wvalid  <= 1'b1;
              aw_done         <= 1'b0;
              w_done          <= 1'b0;
            end
          end
        end
        S_WR: begin
          if (aw_hs) begin
            m00_axi_awvalid <= 1'b0;
            aw_done         <= 1'b1;
          end
          if (w_hs) begin
            m00_axi_wvalid <= 1'b0;
            w_done         <= 1'b1;
          end
          if ((aw_done || aw_hs) && (w_done || w_hs)) begin
            state          <= S_WR_B;
            m00_axi_bready <= 1'b1;
          end
        end
        S_WR_B: begin
          if (m00_axi_bvalid) begin
            m00_axi_bready <= 1'b0;
            sent_cnt       <= sent_cnt + CNT_WIDTH'(1);
            state          <= S_IDLE;
          end
        end
        S_POLL_AR: begin
          if (m00_axi_arready) begin
            m00_axi_arvalid <= 1'b0;
            m00_axi_rready  <= 1'b1;
            state           <= S_POLL_R;
          end
        end
        S_POLL_R: begin
          if (m00_axi_rvalid) begin
            m00_axi_rready <= 1'b0;
            if (m00_axi_rresp == 2'b00 && m00_axi_rdata != '0) begin
              state           <= S_WR;
              m00_axi_awvalid <= 1'b1;
              m00_axi_wvalid  <= 1'b1;
              aw_done         <= 1'b0;
              w_done          <= 1'b0;
            end else begin
              state   <= S_POLL_GAP;
              gap_cnt <= '0;
            end
          end
        end
        S_POLL_GAP: begin
          if (gap_cnt == GW'(POLL_GAP - 1)) begin
            state           <= S_POLL_AR;
            m00_axi_arvalid <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + GW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
    if (!m00_axi_aresetn)
      resp_err <= 1'b0;
    else if ((b_hs && m00_axi_bresp != 2'b00) || (r_hs && m00_axi_rresp != 2'b00))
      resp_err <= 1'b1;
    else if (err_clr)
      resp_err <= 1'b0;
  end

endmodule

// File: tb/tb_axil_order_sequencer.sv
// Directed bench for axil_order_sequencer: responsive AXI-Lite slave model plus
// hand-computed expectations for ordering, stalls, FIFO full, gating, errors and reset.
module tb_axil_order_sequencer;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        cmd_valid, cmd_ready, gate_en, err_clr;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_data;
  logic [7:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        busy, resp_err;
  logic [15:0] sent_cnt;

  always #5 clk = ~clk;

  axil_order_sequencer #(
    .AXIL_DATA_WIDTH(32), .AXIL_ADDR_WIDTH(8), .FIFO_DEPTH(16),
    .GATE_ADDR(8'h48), .STATUS_ADDR(8'h4c), .POLL_GAP(4), .CNT_WIDTH(16)
  ) dut (
    .m00_axi_aclk(clk), .m00_axi_aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .gate_en(gate_en), .err_clr(err_clr),
    .m00_axi_awaddr(awaddr), .m00_axi_awprot(awprot), .m00_axi_awvalid(awvalid), .m00_axi_awready(awready),
    .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb), .m00_axi_wvalid(wvalid), .m00_axi_wready(wready),
    .m00_axi_bresp(bresp), .m00_axi_bvalid(bvalid), .m00_axi_bready(bready),
    .m00_axi_araddr(araddr), .m00_axi_arprot(arprot), .m00_axi_arvalid(arvalid), .m00_axi_arready(arready),
    .m00_axi_rdata(rdata), .m00_axi_rresp(rresp), .m00_axi_rvalid(rvalid), .m00_axi_rready(rready),
    .busy(busy), .sent_cnt(sent_cnt), .resp_err(resp_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Slave model: handshakes observed on the rising edge, responses driven on the falling edge
  logic [7:0]  aw_log[$], ar_log[$];
  logic [31:0] w_log[$], rd_q[$];
  int aw_cyc[$], b_cyc[$], ar_cyc[$], r_cyc[$];
  int cyc = 0, b_cnt = 0, b_raised = 0, err_at = -1;
  int aw_pend = 0, w_pend = 0;
  bit ar_pend = 0, b_hs = 0, r_hs = 0;

  always @(posedge clk) begin
    cyc++;
    if (awvalid && awready) begin aw_log.push_back(awaddr); aw_cyc.push_back(cyc); aw_pend++; end
    if (wvalid && wready) begin w_log.push_back(wdata); w_pend++; end
    if (bvalid && bready) begin b_cnt++; b_cyc.push_back(cyc); b_hs = 1; end
    if (arvalid && arready) begin ar_log.push_back(araddr); ar_cyc.push_back(cyc); ar_pend = 1; end
    if (rvalid && rready) begin r_cyc.push_back(cyc); r_hs = 1; end
  end

  always @(negedge clk) begin
    if (b_hs) begin bvalid = 1'b0; b_hs = 0; end
    if (!bvalid && aw_pend > 0 && w_pend > 0) begin
      bvalid = 1'b1;
      bresp  = (b_raised == err_at) ? 2'b10 : 2'b00;
      b_raised++;
      aw_pend--;
      w_pend--;
    end
    if (r_hs) begin rvalid = 1'b0; r_hs = 0; end
    if (!rvalid && ar_pend) begin
      rvalid  = 1'b1;
      rdata   = (rd_q.size() > 0) ? rd_q.pop_front() : 32'h1;
      ar_pend = 0;
    end
  end

  task automatic push(input logic [7:0] a, input logic [31:0] d);
    int t = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_data  = d;
    while (!cmd_ready && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) check("push_timeout", 0, 1);
  endtask

  task automatic idle_cmd();
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_b(input int target, input int budget, input string tag);
    int t = 0;
    while (b_cnt < target && t < budget) begin @(negedge clk); t++; end
    check(tag, 64'(b_cnt >= target), 1);
  endtask

  task automatic clear_logs();
    aw_log.delete(); w_log.delete(); ar_log.delete();
    aw_cyc.delete(); b_cyc.delete(); ar_cyc.delete(); r_cyc.delete();
  endtask

  int exp_cnt = 0;
  int base, t;

  initial begin
    aresetn = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_data = '0;
    gate_en = 1'b0; err_clr = 1'b0;
    awready = 1'b1; wready = 1'b1; arready = 1'b1;
    bvalid = 1'b0; bresp = 2'b00; rvalid = 1'b0; rdata = '0; rresp = 2'b00;

    repeat (3) @(negedge clk);
    check("rst_awvalid", awvalid, 0);
    check("rst_busy", busy, 0);
    aresetn = 1'b1;
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_sent_cnt", sent_cnt, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_arvalid_bready", {arvalid, bready, rready, wvalid}, 0);

    // Three orders, slave always ready
    clear_logs();
    base = b_cnt;
    push(8'h00, 32'h1); push(8'h04, 32'h2); push(8'h08, 32'h3);
    idle_cmd();
    wait_b(base + 3, 100, "t1_b_timeout");
    exp_cnt += 3;
    check("t1_busy_low", busy, 0);
    check("t1_sent_cnt", sent_cnt, 64'(exp_cnt));
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t1_awaddr%0d", i), aw_log[i], 64'(4 * i));
      check($sformatf("t1_wdata%0d", i), w_log[i], 64'(i + 1));
    end
    check("t1_aw_after_b_gap", 64'((aw_cyc[1] - b_cyc[0]) >= 2), 1);
    check("t1_prot_strb", {awprot, arprot, wstrb}, 64'h00F);

    // awready lags wready by 3 cycles
    clear_logs();
    base = b_cnt;
    awready = 1'b0;
    push(8'h10, 32'h55);
    idle_cmd();
    t = 0;
    while (w_log.size() == 0 && t < 50) begin @(negedge clk); t++; end
    check("t2_w_hs_seen", 64'(w_log.size()), 1);
    check("t2_wvalid_dropped", wvalid, 0);
    check("t2_awvalid_held", awvalid, 1);
    repeat (2) @(negedge clk);
    check("t2_awvalid_still", awvalid, 1);
    check("t2_awaddr_stable", awaddr, 8'h10);
    awready = 1'b1;
    wait_b(base + 1, 50, "t2_b_timeout");
    exp_cnt += 1;
    repeat (10) @(negedge clk);
    check("t2_single_b", 64'(b_cnt - base), 1);
    check("t2_awaddr", aw_log[0], 8'h10);
    check("t2_wdata", w_log[0], 32'h55);
    check("t2_sent_cnt", sent_cnt, 64'(exp_cnt));

    // FIFO fill while the slave stalls: 1 in flight + 16 queued
    clear_logs();
    base = b_cnt;
    awready = 1'b0; wready = 1'b0;
    for (int i = 0; i < 17; i++) push(8'(4 * i), 32'h100 + 32'(i));
    idle_cmd();
    check("t3_cmd_ready_full", cmd_ready, 0);
    check("t3_busy", busy, 1);
    cmd_valid = 1'b1; cmd_addr = 8'hFC; cmd_data = 32'hDEAD;
    t = 0;
    for (int i = 0; i < 5; i++) begin @(negedge clk); if (cmd_ready) t++; end
    check("t3_cmd_ready_stays_low", 64'(t), 0);
    cmd_valid = 1'b0;
    awready = 1'b1; wready = 1'b1;
    wait_b(base + 17, 400, "t3_b_timeout");
    exp_cnt += 17;
    repeat (20) @(negedge clk);
    check("t3_write_count", 64'(aw_log.size()), 17);
    t = 0;
    for (int i = 0; i < 17; i++)
      if (aw_log[i] !== 8'(4 * i) || w_log[i] !== 32'h100 + 32'(i)) t++;
    check("t3_order_mismatches", 64'(t), 0);
    check("t3_sent_cnt", sent_cnt, 64'(exp_cnt));
    check("t3_idle", {busy, cmd_ready}, 2'b01);

    // Gated write: status reads 0,0,5
    clear_logs();
    base = b_cnt;
    gate_en = 1'b1;
    rd_q.push_back(32'h0); rd_q.push_back(32'h0); rd_q.push_back(32'h5);
    push(8'h48, 32'hA5);
    idle_cmd();
    wait_b(base + 1, 200, "t4_b_timeout");
    exp_cnt += 1;
    gate_en = 1'b0;
    check("t4_ar_count", 64'(ar_log.size()), 3);
    for (int i = 0; i < 3; i++) check($sformatf("t4_araddr%0d", i), ar_log[i], 8'h4c);
    check("t4_gap1", 64'(ar_cyc[1] - r_cyc[0]), 5);
    check("t4_gap2", 64'(ar_cyc[2] - r_cyc[1]), 5);
    check("t4_aw_count", 64'(aw_log.size()), 1);
    check("t4_awaddr", aw_log[0], 8'h48);
    check("t4_wdata", w_log[0], 32'hA5);
    check("t4_aw_after_status", 64'(aw_cyc[0] > r_cyc[2]), 1);
    check("t4_sent_cnt", sent_cnt, 64'(exp_cnt));

    // bresp error on the 2nd write, then clear
    clear_logs();
    base = b_cnt;
    check("t5_err_before", resp_err, 0);
    err_at = b_raised + 1;
    push(8'h20, 32'h1); push(8'h24, 32'h2);
    idle_cmd();
    wait_b(base + 2, 100, "t5_b_timeout");
    exp_cnt += 2;
    check("t5_err_set", resp_err, 1);
    repeat (5) @(negedge clk);
    check("t5_err_sticky", resp_err, 1);
    check("t5_sent_cnt", sent_cnt, 64'(exp_cnt));
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("t5_err_cleared", resp_err, 0);

    // Reset mid-transaction with 5 orders queued
    clear_logs();
    awready = 1'b0; wready = 1'b0;
    for (int i = 0; i < 6; i++) push(8'h80 + 8'(4 * i), 32'h200 + 32'(i));
    idle_cmd();
    @(negedge clk);
    check("t6_awvalid_pending", awvalid, 1);
    #2 aresetn = 1'b0;
    #1;
    check("t6_awvalid_dropped", {awvalid, wvalid}, 0);
    check("t6_busy", busy, 0);
    check("t6_sent_cnt", sent_cnt, 0);
    @(negedge clk);
    awready = 1'b1; wready = 1'b1;
    aresetn = 1'b1;
    repeat (30) @(negedge clk);
    check("t6_no_write", 64'(aw_log.size() + w_log.size()), 0);
    check("t6_idle_after", {busy, cmd_ready}, 2'b01);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
